// File: rtl/main_control_fsm.sv
// Multi-cycle main control FSM for the femtoRV32 core: fetch/decode/execute/mem/wb sequencing,
// datapath enables and retired-instruction count. Optional HALT on ECALL/EBREAK via CTRL_HALT_EN.
module main_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  input  logic             branch_cond,
  output logic [1:0]       ALUOp,
  output logic [1:0]       alu_src_a,
  output logic             alu_src_b,
  output logic             mem_req,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             illegal,
  output logic             halted,
  output logic [CNT_W-1:0] retired,
  output logic [2:0]       state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    CL_R, CL_I, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL,
    CL_JALR, CL_LUI, CL_AUIPC, CL_SYS, CL_ILL
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_d, dec_cls;
  logic [CNT_W-1:0] retired_q, retired_d;

`ifndef CTRL_HALT_EN
  logic unused_funct3;
  assign unused_funct3 = ^funct3;
`endif

  always_comb begin
    case (opcode)
      7'b0110011: dec_cls = CL_R;
      7'b0010011: dec_cls = CL_I;
      7'b0000011: dec_cls = CL_LOAD;
      7'b0100011: dec_cls = CL_STORE;
      7'b1100011: dec_cls = CL_BRANCH;
      7'b1101111: dec_cls = CL_JAL;
      7'b1100111: dec_cls = CL_JALR;
      7'b0110111: dec_cls = CL_LUI;
      7'b0010111: dec_cls = CL_AUIPC;
      7'b1110011: dec_cls = CL_SYS;
      default:    dec_cls = CL_ILL;
    endcase
  end

  // {ALUOp, alu_src_a, alu_src_b} for a class; also reused in WB so the result stays valid
  function automatic logic [4:0] alu_ctrl(input cls_t c);
    case (c)
      CL_R:                        alu_ctrl = {2'b10, 2'd0, 1'b0};
      CL_I:                        alu_ctrl = {2'b10, 2'd0, 1'b1};
      CL_LOAD, CL_STORE, CL_JALR:  alu_ctrl = {2'b00, 2'd0, 1'b1};
      CL_AUIPC, CL_JAL:            alu_ctrl = {2'b00, 2'd1, 1'b1};
      CL_LUI:                      alu_ctrl = {2'b00, 2'd2, 1'b1};
      CL_BRANCH:                   alu_ctrl = {2'b01, 2'd0, 1'b0};
      default:                     alu_ctrl = 5'd0;
    endcase
  endfunction

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    ALUOp     = 2'b00;
    alu_src_a = 2'd0;
    alu_src_b = 1'b0;
    mem_req   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'd0;
    pc_write  = 1'b0;
    pc_sel    = 2'd0;
    illegal   = 1'b0;
    halted    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        cls_d = dec_cls;
        case (dec_cls)
          CL_ILL: begin
            illegal  = 1'b1;
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end
          CL_SYS: begin
`ifdef CTRL_HALT_EN
            if (funct3 == 3'b000) begin
              state_d = S_HALT;
            end else begin
              pc_write = 1'b1;
              state_d  = S_FETCH;
            end
`else
            pc_write = 1'b1;
            state_d  = S_FETCH;
`endif
          end
          default: state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        {ALUOp, alu_src_a, alu_src_b} = alu_ctrl(cls_q);
        if (cls_q == CL_BRANCH) begin
          pc_write = 1'b1;
          pc_sel   = branch_cond ? 2'd1 : 2'd0;
          state_d  = S_FETCH;
        end else if (cls_q == CL_LOAD || cls_q == CL_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req   = 1'b1;
        mem_read  = (cls_q == CL_LOAD);
        mem_write = (cls_q == CL_STORE);
        ALUOp     = 2'b00;
        alu_src_a = 2'd0;
        alu_src_b = 1'b1;
        if (mem_ready) begin
          if (cls_q == CL_STORE) begin
            pc_write = 1'b1;
            state_d  = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        {ALUOp, alu_src_a, alu_src_b} = alu_ctrl(cls_q);
        reg_write = 1'b1;
        pc_write  = 1'b1;
        if (cls_q == CL_LOAD) begin
          wb_sel = 2'd1;
        end else if (cls_q == CL_JAL || cls_q == CL_JALR) begin
          wb_sel = 2'd2;
          pc_sel = 2'd2;
        end
        state_d = S_FETCH;
      end
      S_HALT: begin
`ifdef CTRL_HALT_EN
        halted = 1'b1;
`else
        state_d = S_FETCH;
`endif
      end
      default: state_d = S_FETCH;
    endcase

    // reset silences the datapath in the same cycle, not just at the next edge
    if (rst) begin
      ALUOp     = 2'b00;
      alu_src_a = 2'd0;
      alu_src_b = 1'b0;
      mem_req   = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      wb_sel    = 2'd0;
      pc_write  = 1'b0;
      pc_sel    = 2'd0;
      illegal   = 1'b0;
      halted    = 1'b0;
    end
    retired_d = retired_q + CNT_W'(pc_write);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cls_q     <= CL_ILL;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      retired_q <= retired_d;
    end
  end

  assign state   = rst ? 3'd0 : state_q;
  assign retired = rst ? '0 : retired_q;

endmodule
